// File: rtl/isa_pkg.sv
// Shared types and default sizes for the instruction loader and its neighbours.
package isa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        FLUSH = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } loader_state_t;

    localparam int A_DEF = 6;
    localparam int W_DEF = 8;

endpackage

// File: rtl/instr_load_ctrl.sv
// Boot loader for the instruction ROM: takes a length-prefixed byte stream, writes it from
// address 0, then hands the ROM address port to the CPU program counter until Halt.
module instr_load_ctrl
    import isa_pkg::*;
#(
    parameter int A = A_DEF,
    parameter int W = W_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          InValid,
    input  logic [W-1:0]  InData,
    output logic          InReady,
    input  logic [A-1:0]  ProgCounter,
    input  logic          Halt,
    output logic          write_enable,
    output logic [A-1:0]  InstAddress,
    output logic [W-1:0]  InputData,
    output logic          CpuRun,
    output logic          Done,
    output logic [A:0]    LoadCount,
    output logic          ErrLen,
    output loader_state_t StateDbg
);

    localparam int DEPTH = 2 ** A;
    localparam logic [A:0] CNT_ONE = (A + 1)'(1);

    // Handshake: a byte moves when InValid && InReady on a rising edge; InReady
    // depends only on state, never on InValid.
    loader_state_t state_q, state_d;
    logic [A-1:0]  waddr_q;
    logic [W-1:0]  data_q;
    logic [A:0]    count_q;
    logic [A:0]    target_q;
    logic          we_q;
    logic          err_q;
    logic          cpu_run_q;
    logic          done_q;

    logic          hs;
    logic          last_byte;
    logic          len_zero;
    logic          len_over;
    logic [A:0]    len_target;

    assign last_byte  = (count_q + CNT_ONE) == target_q;
    assign len_zero   = (InData == '0);
    assign len_over   = int'(InData) > DEPTH;
    assign len_target = len_over ? (A + 1)'(DEPTH) : (A + 1)'(InData);

    always_comb begin
        state_d = state_q;
        InReady = (state_q == LEN) || (state_q == DATA);
        hs      = InValid && InReady;
        case (state_q)
            IDLE, DONE: if (Start) state_d = LEN;
            LEN:        if (hs) state_d = len_zero ? IDLE : DATA;
            DATA:       if (hs && last_byte) state_d = FLUSH;
            FLUSH:      state_d = RUN;
            RUN:        if (Halt) state_d = DONE;
            default:    state_d = IDLE;
        endcase

        // The CPU owns the ROM address only while running; otherwise it shows the pending write.
        if (state_q == RUN) begin
            InstAddress = ProgCounter;
        end else if (we_q) begin
            InstAddress = waddr_q;
        end else begin
            InstAddress = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            data_q    <= '0;
            count_q   <= '0;
            target_q  <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            cpu_run_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= 1'b0;
            data_q  <= '0;
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        err_q   <= 1'b0;
                        count_q <= '0;
                        waddr_q <= '0;
                        done_q  <= 1'b0;
                    end
                end
                LEN: begin
                    if (hs) begin
                        if (len_zero) begin
                            err_q <= 1'b1;
                        end else begin
                            target_q <= len_target;
                            if (len_over) err_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    // Write index is the count of words already accepted, so N=DEPTH never wraps.
                    if (hs) begin
                        we_q    <= 1'b1;
                        waddr_q <= count_q[A-1:0];
                        data_q  <= InData;
                        count_q <= count_q + CNT_ONE;
                    end
                end
                FLUSH: cpu_run_q <= 1'b1;
                RUN: begin
                    if (Halt) begin
                        cpu_run_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign write_enable = we_q;
    assign InputData    = data_q;
    assign CpuRun       = cpu_run_q;
    assign Done         = done_q;
    assign LoadCount    = count_q;
    assign ErrLen       = err_q;
    assign StateDbg     = state_q;

endmodule
